// File: rtl/PARAMS_BN254_d0.sv
// Shared BN254 field parameters and operand types for the post-adder datapath.
// The redundant form keeps one unsigned value field and one signed carry per limb.
package PARAMS_BN254_d0;

    localparam int unsigned FP_BITS   = 256;
    localparam int unsigned ADD_DIV   = 4;
    localparam int unsigned CARRY_W   = 8;
    localparam int unsigned W         = FP_BITS / ADD_DIV;
    localparam int unsigned RED_STEPS = CARRY_W + 3;
    localparam int unsigned X_W       = FP_BITS + CARRY_W + 3;

    typedef logic [FP_BITS-1:0] uint_fp_t;
    typedef logic signed [X_W-1:0] fp_wide_t;

    localparam uint_fp_t Mod =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    typedef struct packed {
        logic signed [CARRY_W-1:0] carry;
        logic [W-1:0]              val;
    } limb_t;

    typedef struct packed {
        limb_t [ADD_DIV-1:0] limb;
    } redundant_poly_L3;

endpackage

// File: rtl/fp_cond_sub.sv
// Combinational compare-and-subtract of a signed wide value against Mod<<k.
// In add mode it instead lifts a negative value by Mod<<k.
module fp_cond_sub
    import PARAMS_BN254_d0::*;
#(
    parameter int unsigned XWidth = X_W,
    parameter int unsigned KWidth = 4
) (
    input  logic signed [XWidth-1:0] x_i,
    input  logic [KWidth-1:0]        k_i,
    input  logic                     add_i,
    output logic signed [XWidth-1:0] y_o
);

    logic signed [XWidth-1:0] m;

    always_comb begin
        m = XWidth'(Mod) << k_i;
        if (add_i) begin
            y_o = x_i[XWidth-1] ? x_i + m : x_i;
        end else begin
            y_o = (x_i >= m) ? x_i - m : x_i;
        end
    end

endmodule

// File: rtl/l3_canonicalizer.sv
// Resolves the carries of one redundant operand limb by limb, then reduces the
// signed result into [0, Mod) by restoring conditional subtraction.
module l3_canonicalizer #(
    parameter int unsigned RED_STEPS = PARAMS_BN254_d0::RED_STEPS,
    parameter int unsigned X_W       = PARAMS_BN254_d0::X_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  PARAMS_BN254_d0::redundant_poly_L3 din,
    input  logic                              in_valid,
    output logic                              in_ready,
    output PARAMS_BN254_d0::uint_fp_t         dout,
    output logic                              out_valid,
    input  logic                              out_ready
);
    import PARAMS_BN254_d0::*;

    localparam int unsigned S_W   = W + 2;
    localparam int unsigned TOP_W = X_W - FP_BITS;
    localparam int unsigned IDX_W = $clog2(ADD_DIV);

    typedef enum logic [2:0] {
        StIdle,
        StResolve,
        StSignfix,
        StReduce,
        StDone
    } state_e;

    state_e                   state_q;
    redundant_poly_L3         op_q;
    logic signed [1:0]        c_q;
    logic [3:0]               cnt_q;
    logic signed [X_W-1:0]    x_q;
    uint_fp_t                 dout_q;
    logic                     in_ready_q;
    logic                     out_valid_q;

    logic [IDX_W-1:0]         idx;
    logic signed [CARRY_W-1:0] prev_carry;
    logic [S_W-1:0]           s;
    logic signed [1:0]        c_new;
    logic [TOP_W-1:0]         top;
    logic signed [X_W-1:0]    x_res;
    logic signed [X_W-1:0]    x_step;
    logic [3:0]               k;
    logic                     add_mode;

    // Running carry stays within {-1, 0, 1}, so s needs only two bits above the limb.
    always_comb begin
        idx        = cnt_q[IDX_W-1:0];
        prev_carry = (cnt_q != 4'd0) ? op_q.limb[idx - IDX_W'(1)].carry : '0;
        s          = {2'b00, op_q.limb[idx].val}
                   + {{W{c_q[1]}}, c_q}
                   + {{(S_W-CARRY_W){prev_carry[CARRY_W-1]}}, prev_carry};
        c_new      = s[S_W-1:W];
        top        = {{(TOP_W-2){c_new[1]}}, c_new}
                   + {{(TOP_W-CARRY_W){op_q.limb[ADD_DIV-1].carry[CARRY_W-1]}},
                      op_q.limb[ADD_DIV-1].carry};
        x_res      = x_q;
        x_res[idx*W +: W] = s[W-1:0];
        if (idx == IDX_W'(ADD_DIV-1)) begin
            x_res[X_W-1:FP_BITS] = top;
        end
    end

    assign add_mode = (state_q == StSignfix);
    assign k        = add_mode ? 4'(RED_STEPS) : cnt_q;

    fp_cond_sub #(
        .XWidth(X_W),
        .KWidth(4)
    ) u_cond_sub (
        .x_i  (x_q),
        .k_i  (k),
        .add_i(add_mode),
        .y_o  (x_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            dout_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q       <= din;
                        c_q        <= '0;
                        cnt_q      <= '0;
                        x_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StResolve;
                    end
                end
                StResolve: begin
                    x_q <= x_res;
                    c_q <= c_new;
                    if (cnt_q == 4'(ADD_DIV-1)) begin
                        state_q <= StSignfix;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StSignfix: begin
                    x_q     <= x_step;
                    cnt_q   <= 4'(RED_STEPS);
                    state_q <= StReduce;
                end
                StReduce: begin
                    x_q <= x_step;
                    if (cnt_q == 4'd0) begin
                        dout_q      <= x_step[FP_BITS-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_l3_canonicalizer.sv
// Bench for l3_canonicalizer: directed vector table, handshake corner sequences and
// random operands checked against a big-integer V mod Mod model.
module tb_l3_canonicalizer;
    import PARAMS_BN254_d0::*;

    typedef logic signed [299:0] big_t;

    typedef struct {
        string            name;
        redundant_poly_L3 d;
        uint_fp_t         exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    redundant_poly_L3 din;
    logic             in_valid;
    logic             in_ready;
    uint_fp_t         dout;
    logic             out_valid;
    logic             out_ready;

    int   checks = 0;
    int   errors = 0;
    big_t big_m;
    big_t lim;
    vec_t tbl[10];

    always #5 clk = ~clk;

    l3_canonicalizer dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dout     (dout),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Integer value denoted by a redundant operand.
    function automatic big_t value_of(input redundant_poly_L3 d);
        big_t v;
        big_t t;
        v = '0;
        for (int i = 0; i < ADD_DIV; i++) begin
            t = '0;
            t[W-1:0] = d.limb[i].val;
            v = v + (t <<< (W * i));
            t = {{(300-CARRY_W){d.limb[i].carry[CARRY_W-1]}}, d.limb[i].carry};
            v = v + (t <<< (W * (i + 1)));
        end
        return v;
    endfunction

    function automatic uint_fp_t ref_mod(input big_t v);
        big_t r;
        r = v % big_m;
        if (r < 0) r = r + big_m;
        return r[FP_BITS-1:0];
    endfunction

    // Plain encoding: limbs of the low 256 bits, the rest in the top carry.
    function automatic redundant_poly_L3 encode(input big_t v);
        redundant_poly_L3 d;
        for (int i = 0; i < ADD_DIV; i++) begin
            d.limb[i].val   = v[W*i +: W];
            d.limb[i].carry = '0;
        end
        d.limb[ADD_DIV-1].carry = v[FP_BITS +: CARRY_W];
        return d;
    endfunction

    // Same value, but with nonzero carries on the lower limbs.
    function automatic redundant_poly_L3 encode_rippled(input big_t v);
        redundant_poly_L3 d;
        big_t             v2;
        big_t             one;
        one = 1;
        v2 = v - 127 * (one <<< W) + 128 * (one <<< (2 * W)) - 5 * (one <<< (3 * W));
        d = encode(v2);
        d.limb[0].carry = 8'sd127;
        d.limb[1].carry = -8'sd128;
        d.limb[2].carry = 8'sd5;
        return d;
    endfunction

    task automatic chk(input string name, input logic [FP_BITS-1:0] act,
                       input logic [FP_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic run_op(input redundant_poly_L3 d, input uint_fp_t exp, input string name,
                          input int hold);
        int cyc;
        bit busy_ok;
        chk({name, " in_ready before accept"}, FP_BITS'(in_ready), 1);
        din      = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        din      = '1;
        cyc      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && cyc < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (in_ready) busy_ok = 1'b0;
        chk({name, " latency"}, FP_BITS'(cyc), 17);
        chk({name, " in_ready low while busy"}, FP_BITS'(busy_ok), 1);
        chk({name, " dout"}, dout, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({name, " held dout"}, dout, exp);
            chk({name, " held valid/ready"}, FP_BITS'({out_valid, in_ready}), 2'b10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " after handshake valid/ready"}, FP_BITS'({out_valid, in_ready}), 2'b01);
    endtask

    initial begin
        redundant_poly_L3 d;
        big_t             v;
        big_t             one;
        bool_flag: begin end
        one   = 1;
        big_m = '0;
        big_m[FP_BITS-1:0] = Mod;
        lim   = one <<< (FP_BITS + CARRY_W - 1);

        tbl[0] = '{"zero", encode(0), '0};
        tbl[1] = '{"mod-1 rippled", encode_rippled(big_m - 1), Mod - 1};
        tbl[2] = '{"-(mod+1)", encode(-(big_m + 1)), Mod - 1};
        tbl[3] = '{"7mod+3", encode(7 * big_m + 3), 256'd3};
        tbl[4] = '{"max pos", encode(lim - 1), ref_mod(lim - 1)};
        tbl[5] = '{"max neg", encode(-lim + 1), ref_mod(-lim + 1)};
        tbl[6] = '{"mod", encode(big_m), '0};
        tbl[7] = '{"minus one", encode(-1), Mod - 1};
        tbl[8] = '{"-40mod", encode(-40 * big_m), '0};
        tbl[9] = '{"500mod", encode(500 * big_m), '0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", FP_BITS'(in_ready), 1);
        chk("reset out_valid", FP_BITS'(out_valid), 0);
        chk("reset dout", dout, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].d, tbl[i].exp, tbl[i].name, 0);
        end

        // Backpressure: hold DONE for five cycles, then an immediate new accept.
        run_op(encode(12345), 256'd12345, "backpressure", 5);
        run_op(encode(7 * big_m + 3), 256'd3, "after backpressure", 0);

        // Reset sampled at edge 8, mid-REDUCE, discards the operand.
        din      = encode(-1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset out_valid", FP_BITS'(out_valid), 0);
        chk("mid reset dout", dout, '0);
        chk("mid reset in_ready", FP_BITS'(in_ready), 1);
        begin
            bit quiet;
            quiet = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (out_valid || !in_ready) quiet = 1'b0;
            end
            chk("no output after reset", FP_BITS'(quiet), 1);
        end
        run_op(encode(7 * big_m + 3), 256'd3, "after mid reset", 0);

        for (int n = 0; n < 150; n++) begin
            do begin
                for (int i = 0; i < ADD_DIV; i++) begin
                    case ($urandom_range(0, 3))
                        0:       d.limb[i].val = '1;
                        1:       d.limb[i].val = '0;
                        default: d.limb[i].val = {$urandom(), $urandom()};
                    endcase
                    d.limb[i].carry = ($urandom_range(0, 1) == 0) ? CARRY_W'($urandom())
                                    : CARRY_W'($urandom_range(0, 4) - 2);
                end
                v = value_of(d);
            end while (v >= lim || v <= -lim);
            run_op(d, ref_mod(v), "random", (n % 7 == 0) ? 2 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
